// File: rtl/wb_burst_ram.sv
// Wishbone B4 single-port RAM with registered feedback: classic, constant and incrementing/wrap bursts.
// Optional macro WB_BURST_RAM_ERR_EN: accesses beyond DEPTH words get wb_err_o instead of wrapping.
module wb_burst_ram #(
    parameter int aw    = 32,
    parameter int DEPTH = 256
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int WW = aw - 2;

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   mem [DEPTH];

    logic [WW-1:0] wadr_cur, wadr_inc, wadr_nxt, wrap_mask, rd_wadr;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [31:0]   wr_merged, rd_word;
    logic          req, burst_cont, wr_en, rd_oob, wr_oob, load;
    logic          unused;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

    // Next-beat address: only the bits inside the wrap window advance.
    always_comb begin
        wadr_cur = wb_adr_i[aw-1:2];
        wadr_inc = wadr_cur + WW'(1);
        case (wb_bte_i)
            2'b01:   wrap_mask = WW'(3);
            2'b10:   wrap_mask = WW'(7);
            2'b11:   wrap_mask = WW'(15);
            default: wrap_mask = '1;
        endcase
        if (wb_cti_i == 3'b010)
            wadr_nxt = (wadr_cur & ~wrap_mask) | (wadr_inc & wrap_mask);
        else
            wadr_nxt = wadr_cur;
        rd_wadr = (state_q == BURST) ? wadr_nxt : wadr_cur;
    end

`ifdef WB_BURST_RAM_ERR_EN
    assign rd_oob = (rd_wadr >> IW) != '0;
    assign wr_oob = (wadr_cur >> IW) != '0;
`else
    assign rd_oob = 1'b0;
    assign wr_oob = 1'b0;
`endif

    assign req        = wb_cyc_i & wb_stb_i;
    assign burst_cont = (state_q == BURST) & ack_q & req &
                        ((wb_cti_i == 3'b001) | (wb_cti_i == 3'b010));
    assign wr_en      = ~wb_rst_i & (state_q == BURST) & ack_q & req & wb_we_i & ~wr_oob;

    // A write landing on the word being fetched is forwarded so dat_o never goes stale.
    always_comb begin
        wr_idx    = wadr_cur[IW-1:0];
        rd_idx    = rd_wadr[IW-1:0];
        wr_merged = merge_bytes(mem[wr_idx], wb_dat_i, wb_sel_i);
        rd_word   = (wr_en && (wr_idx == rd_idx)) ? wr_merged : mem[rd_idx];
    end

    always_comb begin
        state_d = IDLE;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        load    = 1'b0;
        case (state_q)
            IDLE:    load = req;
            BURST:   load = burst_cont;
            default: load = 1'b0;
        endcase
        if (load) begin
            state_d = BURST;
            if (rd_oob) begin
                err_d = 1'b1;
                dat_d = '0;
            end else begin
                ack_d = 1'b1;
                dat_d = rd_word;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr_en)
            mem[wr_idx] <= wr_merged;
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

    assign unused = ^{wb_adr_i[1:0], rd_wadr, wadr_cur};
endmodule

// File: tb/tb_wb_burst_ram.sv
// Self-checking bench for wb_burst_ram: random data against a word-array model of the RAM.
module tb_wb_burst_ram;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat_i, dat_o;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, err, rty;
    logic [2:0]  cti;
    logic [1:0]  bte;

    always #5 clk = ~clk;

    wb_burst_ram #(.aw(32), .DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .wb_err_o(err), .wb_rty_o(rty)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] beat_adr [16];
    logic [31:0] beat_dat [16];
    logic [3:0]  beat_sel [16];
    logic [31:0] obs_dat  [16];
    int          obs_wait [16];
    logic        obs_err  [16];
    logic        end_ack;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem[widx(a)];
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) model_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic logic [31:0] wrap_adr(input logic [31:0] a0, input int k, input int words);
        logic [31:0] span;
        span = 32'(words * 4);
        return (a0 & ~(span - 1)) | ((a0 + 32'(4 * k)) & (span - 1));
    endfunction

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
        sel = 4'h0; adr = '0; dat_i = '0;
    endtask

    // Master: presents beat_* in order, records wait cycles and returned data per beat.
    task automatic wb_run(input int n, input logic w_en, input logic [2:0] cti_b, input logic [1:0] bt);
        int w;
        for (int i = 0; i < n; i++) begin
            cyc = 1'b1; stb = 1'b1; we = w_en; bte = bt;
            adr = beat_adr[i]; dat_i = beat_dat[i]; sel = beat_sel[i];
            cti = (i == n - 1 && cti_b != 3'b000) ? 3'b111 : cti_b;
            w = 0;
            while (!ack && !err && w < 8) begin
                @(posedge clk); #1;
                w++;
            end
            obs_wait[i] = (ack || err) ? w : -1;
            obs_dat[i]  = dat_o;
            obs_err[i]  = err;
            @(posedge clk); #1;
        end
        end_ack = ack | err;
        bus_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; dat_i = 32'h1; sel = 4'hF; cti = 3'b000; bte = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b expected 0", ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err); end
        checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h expected 0", dat_o); end
        checks++; if (rty !== 1'b0) begin errors++; $display("FAIL reset_rty got %b expected 0", rty); end
        bus_idle();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) begin
                beat_adr[i] = 32'(b * 64 + i * 4);
                beat_dat[i] = $urandom;
                beat_sel[i] = 4'hF;
            end
            wb_run(16, 1'b1, 3'b010, 2'b00);
            for (int i = 0; i < 16; i++) begin
                model_write(beat_adr[i], beat_dat[i], beat_sel[i]);
                checks++;
                if (obs_wait[i] !== ((i == 0) ? 1 : 0)) begin
                    errors++; $display("FAIL fill_wait beat %0d got %0d expected %0d", i, obs_wait[i], (i == 0) ? 1 : 0);
                end
            end
            checks++; if (end_ack !== 1'b0) begin errors++; $display("FAIL fill_end_ack got %b expected 0", end_ack); end
        end
    endtask

    task automatic test_classic();
        beat_adr[0] = 32'h10; beat_dat[0] = 32'hDEAD_BEEF; beat_sel[0] = 4'hF;
        wb_run(1, 1'b1, 3'b000, 2'b00);
        model_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        checks++; if (obs_wait[0] !== 1) begin errors++; $display("FAIL classic_wr_latency got %0d expected 1", obs_wait[0]); end
        checks++; if (end_ack !== 1'b0) begin errors++; $display("FAIL classic_wr_ack_low got %b expected 0", end_ack); end
        beat_dat[0] = $urandom;
        wb_run(1, 1'b0, 3'b000, 2'b00);
        checks++; if (obs_wait[0] !== 1) begin errors++; $display("FAIL classic_rd_latency got %0d expected 1", obs_wait[0]); end
        checks++; if (obs_dat[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL classic_rd_data got %h expected deadbeef", obs_dat[0]); end
        checks++; if (end_ack !== 1'b0) begin errors++; $display("FAIL classic_rd_ack_low got %b expected 0", end_ack); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            beat_adr[i] = 32'($urandom_range(0, DEPTH - 1) * 4);
            beat_sel[i] = 4'($urandom);
            beat_dat[i] = $urandom;
        end
        wb_run(4, 1'b0, 3'b000, 2'b00);
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_wait[i] !== 1) begin errors++; $display("FAIL b2b_wait beat %0d got %0d expected 1", i, obs_wait[i]); end
            checks++; if (obs_dat[i] !== model_read(beat_adr[i])) begin
                errors++; $display("FAIL b2b_data beat %0d got %h expected %h", i, obs_dat[i], model_read(beat_adr[i]));
            end
        end
    endtask

    task automatic test_byte_sel();
        logic [31:0] a;
        beat_adr[0] = 32'h20; beat_dat[0] = 32'hFFFF_FFFF; beat_sel[0] = 4'hF;
        wb_run(1, 1'b1, 3'b000, 2'b00);
        beat_dat[0] = 32'h1234_5678; beat_sel[0] = 4'h3;
        wb_run(1, 1'b1, 3'b000, 2'b00);
        wb_run(1, 1'b0, 3'b000, 2'b00);
        checks++; if (obs_dat[0] !== 32'hFFFF_5678) begin errors++; $display("FAIL sel_merge got %h expected ffff5678", obs_dat[0]); end
        model_write(32'h20, 32'hFFFF_5678, 4'hF);
        for (int k = 0; k < 4; k++) begin
            a = 32'($urandom_range(0, DEPTH - 1) * 4);
            beat_adr[0] = a; beat_dat[0] = $urandom; beat_sel[0] = 4'($urandom);
            wb_run(1, 1'b1, 3'b000, 2'b00);
            model_write(a, beat_dat[0], beat_sel[0]);
            wb_run(1, 1'b0, 3'b000, 2'b00);
            checks++; if (obs_dat[0] !== model_read(a)) begin
                errors++; $display("FAIL sel_random adr %h got %h expected %h", a, obs_dat[0], model_read(a));
            end
        end
    endtask

    task automatic test_linear_burst();
        for (int i = 0; i < 4; i++) begin
            beat_adr[i] = 32'h40 + 32'(4 * i); beat_dat[i] = $urandom; beat_sel[i] = 4'hF;
        end
        wb_run(4, 1'b1, 3'b010, 2'b00);
        for (int i = 0; i < 4; i++) model_write(beat_adr[i], beat_dat[i], 4'hF);
        wb_run(4, 1'b0, 3'b010, 2'b00);
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_wait[i] !== ((i == 0) ? 1 : 0)) begin
                errors++; $display("FAIL linear_wait beat %0d got %0d expected %0d", i, obs_wait[i], (i == 0) ? 1 : 0);
            end
            checks++; if (obs_dat[i] !== model_read(beat_adr[i])) begin
                errors++; $display("FAIL linear_data beat %0d got %h expected %h", i, obs_dat[i], model_read(beat_adr[i]));
            end
        end
        checks++; if (end_ack !== 1'b0) begin errors++; $display("FAIL linear_end_ack got %b expected 0", end_ack); end
    endtask

    task automatic test_wrap();
        logic [31:0] a0;
        int words;
        for (int i = 0; i < 4; i++) begin
            beat_adr[i] = wrap_adr(32'h38, i, 4); beat_dat[i] = 32'(i + 1); beat_sel[i] = 4'hF;
        end
        wb_run(4, 1'b1, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) model_write(beat_adr[i], beat_dat[i], 4'hF);
        beat_adr[0] = 32'h38; beat_adr[1] = 32'h3C; beat_adr[2] = 32'h30; beat_adr[3] = 32'h34;
        wb_run(4, 1'b0, 3'b000, 2'b00);
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_dat[i] !== 32'(i + 1)) begin
                errors++; $display("FAIL wrap4_data adr %h got %h expected %h", beat_adr[i], obs_dat[i], 32'(i + 1));
            end
        end
        for (int m = 0; m < 2; m++) begin
            words = (m == 0) ? 8 : 16;
            a0 = 32'($urandom_range(0, DEPTH - 1) * 4);
            for (int i = 0; i < words; i++) begin
                beat_adr[i] = wrap_adr(a0, i, words); beat_dat[i] = '0; beat_sel[i] = 4'hF;
            end
            wb_run(words, 1'b0, 3'b010, (m == 0) ? 2'b10 : 2'b11);
            for (int i = 0; i < words; i++) begin
                checks++; if (obs_wait[i] !== ((i == 0) ? 1 : 0) || obs_dat[i] !== model_read(beat_adr[i])) begin
                    errors++; $display("FAIL wrap%0d beat %0d adr %h got %h/%0d expected %h/%0d", words, i, beat_adr[i],
                                       obs_dat[i], obs_wait[i], model_read(beat_adr[i]), (i == 0) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_const_forward();
        logic [31:0] a;
        logic [31:0] expv [4];
        a = 32'($urandom_range(0, DEPTH - 1) * 4);
        for (int i = 0; i < 4; i++) begin
            beat_adr[i] = a; beat_dat[i] = $urandom; beat_sel[i] = 4'($urandom_range(1, 15));
            expv[i] = model_read(a);
            model_write(a, beat_dat[i], beat_sel[i]);
        end
        wb_run(4, 1'b1, 3'b001, 2'b00);
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_dat[i] !== expv[i] || obs_wait[i] !== ((i == 0) ? 1 : 0)) begin
                errors++; $display("FAIL const_fwd beat %0d got %h/%0d expected %h/%0d", i, obs_dat[i], obs_wait[i], expv[i], (i == 0) ? 1 : 0);
            end
        end
        wb_run(1, 1'b0, 3'b000, 2'b00);
        checks++; if (obs_dat[0] !== model_read(a)) begin errors++; $display("FAIL const_final got %h expected %h", obs_dat[0], model_read(a)); end
    endtask

    task automatic test_stb_drop();
        logic [31:0] a, b, x, y;
        int w;
        a = 32'($urandom_range(0, 250) * 4);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF; cti = 3'b010; bte = 2'b00;
        w = 0;
        while (!ack && w < 8) begin @(posedge clk); #1; w++; end
        checks++; if (w !== 1 || dat_o !== model_read(a)) begin errors++; $display("FAIL drop_first got %h/%0d expected %h/1", dat_o, w, model_read(a)); end
        @(posedge clk); #1;
        checks++; if (ack !== 1'b1 || dat_o !== model_read(a + 4)) begin
            errors++; $display("FAIL drop_second got %h/%b expected %h/1", dat_o, ack, model_read(a + 4));
        end
        adr = a + 4; stb = 1'b0;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL drop_rd_ack got %b expected 0", ack); end
        bus_idle();
        @(posedge clk); #1;
        b = 32'($urandom_range(0, 250) * 4); x = $urandom; y = $urandom;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = b; dat_i = x; sel = 4'hF; cti = 3'b010;
        w = 0;
        while (!ack && w < 8) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        model_write(b, x, 4'hF);
        adr = b + 4; dat_i = y; stb = 1'b0;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL drop_wr_ack got %b expected 0", ack); end
        stb = 1'b1; we = 1'b0; cti = 3'b000;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b1 || dat_o !== model_read(b + 4)) begin
            errors++; $display("FAIL drop_restart got %h/%b expected %h/1", dat_o, ack, model_read(b + 4));
        end
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL drop_restart_end got %b expected 0", ack); end
        bus_idle();
        beat_adr[0] = b; beat_sel[0] = 4'hF; beat_dat[0] = '0;
        wb_run(1, 1'b0, 3'b000, 2'b00);
        checks++; if (obs_dat[0] !== x) begin errors++; $display("FAIL drop_wr_data got %h expected %h", obs_dat[0], x); end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] b0;
        int w;
        b0 = $urandom;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h100; dat_i = b0; sel = 4'hF; cti = 3'b010; bte = 2'b00;
        w = 0;
        while (!ack && w < 8) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        model_write(32'h100, b0, 4'hF);
        adr = 32'h104; dat_i = ~b0; rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0 || err !== 1'b0 || dat_o !== 32'h0) begin
            errors++; $display("FAIL midrst_outputs got ack=%b err=%b dat=%h expected 0/0/0", ack, err, dat_o);
        end
        rst = 1'b0;
        bus_idle();
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            beat_adr[i] = 32'h100 + 32'(4 * i); beat_dat[i] = '0; beat_sel[i] = 4'hF;
        end
        wb_run(8, 1'b0, 3'b010, 2'b00);
        for (int i = 0; i < 8; i++) begin
            checks++; if (obs_dat[i] !== model_read(beat_adr[i])) begin
                errors++; $display("FAIL midrst_mem adr %h got %h expected %h", beat_adr[i], obs_dat[i], model_read(beat_adr[i]));
            end
        end
    endtask

    task automatic test_out_of_range();
        beat_adr[0] = 32'h400; beat_dat[0] = '0; beat_sel[0] = 4'hF;
        wb_run(1, 1'b0, 3'b000, 2'b00);
        checks++; if (obs_wait[0] !== 1) begin errors++; $display("FAIL oor_latency got %0d expected 1", obs_wait[0]); end
`ifdef WB_BURST_RAM_ERR_EN
        checks++; if (obs_err[0] !== 1'b1 || obs_dat[0] !== 32'h0) begin
            errors++; $display("FAIL oor_err got err=%b dat=%h expected 1/0", obs_err[0], obs_dat[0]);
        end
`else
        checks++; if (obs_err[0] !== 1'b0 || obs_dat[0] !== model_mem[0]) begin
            errors++; $display("FAIL oor_alias got err=%b dat=%h expected 0/%h", obs_err[0], obs_dat[0], model_mem[0]);
        end
`endif
        checks++; if (end_ack !== 1'b0) begin errors++; $display("FAIL oor_end got %b expected 0", end_ack); end
    endtask

    initial begin
        bus_idle();
        rst = 1'b1;
        test_reset();
        test_fill();
        test_classic();
        test_back_to_back();
        test_byte_sel();
        test_linear_burst();
        test_wrap();
        test_const_forward();
        test_stb_drop();
        test_reset_mid_burst();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_burst_ram.md
WB_BURST_RAM -- requirements
Module: wb_burst_ram

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter aw, default 32, meaning Wishbone byte-address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning memory size in 32-bit words (power of two, 4..2^(aw-2)).
REQ-004 wb_clk_i  input  1  clock.
REQ-005 wb_rst_i  input  1  synchronous active-high reset.
REQ-006 wb_adr_i  input  aw  byte address; bits [1:0] ignored.
REQ-007 wb_dat_i  input  32  write data.
REQ-008 wb_sel_i  input  4  byte lane enables, bit n = wb_dat_i[8n+7:8n].
REQ-009 wb_we_i  input  1  1 = write, 0 = read.
REQ-010 wb_cyc_i  input  1  bus cycle active.
REQ-011 wb_stb_i  input  1  beat strobe.
REQ-012 wb_cti_i  input  3  cycle type: 000 classic, 001 constant burst, 010 incrementing burst, 111 end of burst.
REQ-013 wb_bte_i  input  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
REQ-014 wb_dat_o  output  32  read data, registered.
REQ-015 wb_ack_o  output  1  beat acknowledge, registered.
REQ-016 wb_err_o  output  1  beat error, registered.
REQ-017 wb_rty_o  output  1  retry, tied 0.

Function
REQ-018 A beat SHALL complete on a rising edge where (wb_ack_o|wb_err_o)&wb_cyc_i&wb_stb_i; a write commits only on a completing edge with wb_ack_o=1, using wb_adr_i, wb_dat_i and wb_sel_i sampled at that edge.
REQ-019 States SHALL be IDLE and BURST; reset state is IDLE.
REQ-020 In IDLE, on an edge where wb_cyc_i&wb_stb_i and wb_ack_o=0, the block SHALL assert wb_ack_o on the next cycle and load wb_dat_o with mem[wb_adr_i word index]; first-beat latency is one cycle.
REQ-021 On a completing edge with wb_cti_i of 001 or 010, the block SHALL enter or stay in BURST, hold wb_ack_o=1, and load wb_dat_o from the predicted next address, giving one beat per cycle.
REQ-022 Predicted next address: cti 001 is the same address; cti 010 with bte 00 is adr+4; with bte 01/10/11, only bits [3:2]/[4:2]/[5:2] increment, modulo 4/8/16, and upper bits stay unchanged.
REQ-023 On a completing edge with wb_cti_i of 000, 111 or a reserved value (011..110), the block SHALL deassert wb_ack_o next cycle and go to IDLE, so classic beats are separated by at least one cycle with ack low.
REQ-024 In BURST, if wb_cyc_i=0 or wb_stb_i=0 at an edge, the block SHALL commit no write, deassert wb_ack_o, and go to IDLE; a later strobe restarts per REQ-020 using wb_adr_i.
REQ-025 When a write commits to the same word the block reads on that edge (constant burst), wb_dat_o SHALL receive the byte-merged new data (write-through forwarding).
REQ-026 For reads, wb_sel_i SHALL be ignored and all 32 bits returned.
REQ-027 wb_err_o SHALL be 0 whenever WB_BURST_RAM_ERR_EN is undefined.

Reset
REQ-028 On a rising edge with wb_rst_i=1: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, state=IDLE, and no write commits on that edge.
REQ-029 Reset SHALL NOT clear memory contents; reset mid-burst SHALL terminate the burst, and outputs SHALL be low from the following cycle.

Configuration
REQ-030 With macro WB_BURST_RAM_ERR_EN defined, an access whose word index is ≥DEPTH SHALL get wb_err_o=1 (wb_ack_o=0, wb_dat_o=0) with the same timing as ack, commit no write, and return to IDLE after the error beat even mid-burst.
REQ-031 Without WB_BURST_RAM_ERR_EN, the word index SHALL be taken modulo DEPTH (low log2(DEPTH) bits), and wb_err_o SHALL be constant 0.

Verification
REQ-032 Classic write 0x10=0xDEADBEEF, sel=4'hF, then classic read 0x10 -> ack one cycle after stb each time, ack low ≥1 cycle between, read returns 0xDEADBEEF.
REQ-033 Classic write 0x20 sel=4'h3 data 0x1234_5678 over prior 0xFFFFFFFF -> read 0x20 returns 0xFFFF5678.
REQ-034 Incrementing linear read burst of 4 from 0x40 (cti 010,010,010,111) -> acks on 4 consecutive cycles, data from 0x40,0x44,0x48,0x4C, ack low after last beat.
REQ-035 Wrap4 write burst of 4 starting 0x38 with data 1..4 -> words 0x38,0x3C,0x30,0x34 hold 1,2,3,4.
REQ-036 Reset asserted on 2nd beat of 8-beat burst -> ack low next cycle, beats 2..8 not written, memory from beat 1 retained.
REQ-037 With WB_BURST_RAM_ERR_EN, DEPTH=256, read at 0x400 -> wb_err_o pulses one cycle, wb_ack_o stays 0; without it -> ack, data of word 0x000.
